// File: rtl/ledring_pkg.sv
// Shared types and default timing for the LED ring serial transmitter.
// No logic here; constants only.
// Not applicable (package).
package ledring_pkg;

    // Transmitter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // One pixel as the LEDs expect it on the wire: green first, then red, then blue
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    // Default timing in 50 MHz clock cycles
    localparam int DEF_NUM_LEDS = 16;
    localparam int DEF_T0H      = 20;     // 0.4 us high for a 0-bit
    localparam int DEF_T1H      = 40;     // 0.8 us high for a 1-bit
    localparam int DEF_TBIT     = 62;     // full bit period
    localparam int DEF_TRESET   = 15000;  // 300 us latch gap
    localparam int PIXEL_BITS   = 24;

endpackage

// File: rtl/ledring_tx.sv
// Serialises a NUM_LEDS pixel frame buffer onto a single-wire LED ring (inverted output).
// Latency: first bit edge one cycle after start; done NUM_LEDS*24*TBIT+TRESET cycles after start.
// No backpressure: start is honoured only in IDLE, frame-buffer writes are always accepted.
module ledring_tx
    import ledring_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int TRESET   = DEF_TRESET
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_LEDS)-1:0] wr_addr,
    input  logic [23:0]                 wr_grb,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        ring_n
);

    localparam int AW   = $clog2(NUM_LEDS);
    localparam int TMAX = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TBIT_LAST   = TW'(TBIT - 1);
    localparam logic [TW-1:0] TRESET_LAST = TW'(TRESET - 1);
    localparam logic [TW-1:0] T0H_C       = TW'(T0H);
    localparam logic [TW-1:0] T1H_C       = TW'(T1H);
    localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_LEDS - 1);
    localparam logic [4:0]    TOP_BIT     = 5'(PIXEL_BITS - 1);

    pixel_t          fb [NUM_LEDS];
    state_t          state;
    state_t          state_nx;
    logic [TW-1:0]   timer;
    logic [4:0]      bit_cnt;
    logic [AW-1:0]   idx;
    logic [23:0]     shreg;
    logic            bit_end;
    logic            last_bit;
    logic            last_pix;
    logic            latch_end;
    logic            line;

    assign bit_end   = (state == SEND) && (timer == TBIT_LAST);
    assign last_bit  = (bit_cnt == 5'd0);
    assign last_pix  = (idx == LAST_IDX);
    assign latch_end = (state == LATCH) && (timer == TRESET_LAST);
    assign busy      = (state != IDLE);

    // Un-inverted line level: high for the first T1H/T0H cycles of each bit, low elsewhere
    always_comb begin
        line = 1'b0;
        if (state == SEND) begin
            line = (timer < (shreg[23] ? T1H_C : T0H_C));
        end
    end

    // Frame buffer; out-of-range addresses are dropped, writes allowed while sending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                fb[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < NUM_LEDS)) begin
            fb[wr_addr] <= pixel_t'(wr_grb);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: start only counts in IDLE, frame ends after the last bit of the last pixel
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SEND;
            SEND:    if (bit_end && last_bit && last_pix) state_nx = LATCH;
            LATCH:   if (latch_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bit timer, shifter, pixel index and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            shreg   <= '0;
            done    <= 1'b0;
            ring_n  <= 1'b1;
        end else begin
            done   <= latch_end;
            ring_n <= ~line;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= fb[0];
                        timer   <= '0;
                        bit_cnt <= TOP_BIT;
                        idx     <= '0;
                    end
                end
                SEND: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (!last_bit) begin
                            shreg   <= {shreg[22:0], 1'b0};
                            bit_cnt <= bit_cnt - 5'd1;
                        end else if (!last_pix) begin
                            // pixel captured here; a write landing this same cycle waits for the next frame
                            idx     <= idx + 1'b1;
                            shreg   <= fb[idx + 1'b1];
                            bit_cnt <= TOP_BIT;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LATCH: begin
                    timer <= latch_end ? '0 : timer + 1'b1;
                end
                default: timer <= '0;
            endcase
        end
    end

endmodule

// File: doc/ledring_tx.md
LEDRING_TX -- requirements
Module: ledring_tx

Interface
REQ-001 Parameter NUM_LEDS, default 16, is the number of pixels in the display-board LED ring.
REQ-002 Parameter T0H, default 20, is the high time of a 0-bit in clk cycles (0.4 us at 50 MHz).
REQ-003 Parameter T1H, default 40, is the high time of a 1-bit in clk cycles (0.8 us).
REQ-004 Parameter TBIT, default 62, is the total bit period in clk cycles.
REQ-005 Parameter TRESET, default 15000, is the latch gap in clk cycles (300 us).
REQ-006 clk  input  1  single clock for all state, CLOCK_50 at top level.
REQ-007 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-008 wr_en  input  1  frame-buffer write strobe.
REQ-009 wr_addr  input  $clog2(NUM_LEDS)  pixel index to write.
REQ-010 wr_grb  input  24  pixel colour {G[7:0],R[7:0],B[7:0]}.
REQ-011 start  input  1  single-cycle request to transmit one frame.
REQ-012 busy  output  1  high while a frame or latch gap is in progress.
REQ-013 done  output  1  one-cycle pulse at frame completion.
REQ-014 ring_n  output  1  registered, inverted serial data; drives LEDRINGn.

Function
REQ-015 Frame buffer SHALL hold NUM_LEDS x 24-bit registers, written on any cycle with wr_en=1, including while busy.
REQ-016 Writes with wr_addr >= NUM_LEDS SHALL be ignored.
REQ-017 FSM states: IDLE, SEND, LATCH.
REQ-018 IDLE: ring_n=1 and busy=0; start=1 loads pixel 0 into the shift register, clears the bit timer, sets bit count 23, and enters SEND.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 SEND: the timer counts 0..TBIT-1; the line is high while timer < T1H (MSB=1) or timer < T0H (MSB=0), and low otherwise.
REQ-021 ring_n SHALL be the registered complement of the line, so ring_n lags state by one cycle and high/low durations are exact.
REQ-022 At timer = TBIT-1 with bit count > 0, the block SHALL shift left and decrement the bit count. Bits go out MSB first, so G[7] is sent first.
REQ-023 At timer = TBIT-1 with bit count = 0 and index < NUM_LEDS-1, the block SHALL increment the index and load the next pixel from the frame buffer.
REQ-024 At timer = TBIT-1 with bit count = 0 and index = NUM_LEDS-1, the block SHALL enter LATCH with the timer cleared.
REQ-025 A pixel SHALL be captured when it is loaded. A write to the same address in the load cycle does not affect the current frame (old value is sent).
REQ-026 LATCH: line low for TRESET cycles; then IDLE, with done=1 for exactly one cycle and busy=0 in that same cycle.
REQ-027 start in the done cycle SHALL be accepted (back-to-back frames).
REQ-028 Frame duration from start sample to done: NUM_LEDS*24*TBIT + TRESET cycles (38808 at defaults).
REQ-029 Timer width SHALL cover max(TBIT, TRESET) without wrap.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, ring_n=1, busy=0, done=0, timer/index/bit count=0, and all frame-buffer entries = 24'h000000.
REQ-031 Reset mid-frame SHALL abort at once, with no latch gap, and done SHALL not pulse.

Structure
REQ-032 Package ledring_pkg SHALL hold the state enum typedef, the pixel struct {g,r,b} and the default timing constants.
REQ-033 No sub-module; the single flat module carries the frame buffer, FSM, timer and shifter.

Verification
REQ-034 Reset, then start with all pixels 0 -> 384 bits, each ring_n low 20 / high 42 cycles; ring_n high for 15000 cycles; done at cycle 38808; busy low the same cycle.
REQ-035 Write pixel0=24'hFF0080 (G=FF, R=00, B=80), then start -> first 24 ring_n low pulses are 40x8, 20x8, 40, 20x7 cycles.
REQ-036 start held high 3 cycles, then start again at cycle 1000 -> exactly one frame, done pulses once.
REQ-037 start asserted in the done cycle -> second frame begins with no extra idle; ring_n stays high 15000 cycles between frames.
REQ-038 During pixel 2, write pixel 2=24'hFFFFFF and pixel 5=24'hFFFFFF -> pixel 2 is sent with its old value; pixel 5 is sent as all 1-bits (40-cycle lows).
REQ-039 rst_n low at cycle 5000 -> ring_n=1 and busy=0 in the same cycle, no done pulse; after release, start sends all-zero pixels.
